sy_rom_arb: RTL and testbench
=============================

Name: sy_rom_arb

Overview:
- Shares one single-port, read-only ROM read port between N_REQ requesters, e.g. core fetch, debug module and DMA.
- ROM port protocol: en/addr in, rdata valid exactly one cycle after en.
- Sits between the requesters and the TL-to-register bridge feeding the boot ROM.
- Does round-robin arbitration, issues one read per cycle when the response path allows, and buffers a response the requester is not ready to take.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, ROM data width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-low.
- req_i  in  N_REQ  per-requester read request; held until granted.
- addr_i  in  N_REQ*ADDR_WIDTH  per-requester address; slice k belongs to requester k.
- gnt_o  out  N_REQ  one-hot grant; request accepted in this cycle.
- rvalid_o  out  N_REQ  one-hot response valid.
- rready_i  in  N_REQ  per-requester response ready.
- rdata_o  out  DATA_WIDTH  response data, shared bus; qualified by rvalid_o.
- rom_en_o  out  1  ROM read enable.
- rom_addr_o  out  ADDR_WIDTH  ROM address.
- rom_rdata_i  in  DATA_WIDTH  ROM data, valid the cycle after rom_en_o.

Behaviour:
- Reset values:
  - gnt_o=0, rvalid_o=0, rdata_o=0, rom_en_o=0, rom_addr_o=0.
  - state=IDLE; round-robin pointer=0, meaning requester 0 has highest priority.
- States:
  - IDLE: no read in flight.
  - RESP: ROM data returning this cycle.
  - HOLD: data buffered, awaiting rready.
- Issue rule:
  - A grant may be issued in IDLE, or in RESP when the current responder's rready_i=1 in that same cycle.
  - Winner = first asserted req_i at or after the pointer, wrapping modulo N_REQ.
  - On issue, in the same cycle: gnt_o[w]=1, rom_en_o=1, rom_addr_o=addr_i[w] (all combinational).
  - Registered: owner<=w, pointer<=(w+1) mod N_REQ, state<=RESP.
- RESP:
  - rvalid_o[owner]=1 and rdata_o=rom_rdata_i.
  - If rready_i[owner]=1: response completes. Next state is RESP if a new grant is issued this cycle, else IDLE.
  - If rready_i[owner]=0: rom_rdata_i is captured into the hold register, no grant is issued, state<=HOLD.
- HOLD:
  - rvalid_o[owner]=1 and rdata_o=hold register.
  - No grant is issued in HOLD.
  - On rready_i[owner]=1, state<=IDLE. The next grant is therefore at earliest the following cycle.
- Throughput and latency:
  - Sustained one read per cycle when requesters are always ready.
  - Latency from grant to rvalid is 1 cycle.
- Outside RESP/HOLD: rvalid_o=0 and rdata_o holds its last value.
- Deasserting req_i before it is granted is legal; the requester simply drops out of arbitration.
- A requester may re-request in the same cycle its response completes. It is eligible, but the pointer has moved past it.
- A requester that is granted while another requester's response completes is legal; responses are strictly in grant order, with at most 1 outstanding.
- Reset asserted mid-read discards the in-flight read and the hold register, and all state returns to reset values. No response is emitted after reset.
- rom_en_o is never asserted while in HOLD, or in RESP with rready low.
- At most one bit of gnt_o and of rvalid_o is set in any cycle.

Optional Feature:
- Macro: SY_ROM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index asserted req_i always wins, the pointer register is removed, and a requester can be starved.
- Undefined (default): round-robin as above.
- Issue and response timing are identical in both modes.

Test Plan:
- Single read:
  - Stimulus: N_REQ=2, req_i=01, addr=0x1000_0000; ROM model returns 0xDEAD_BEEF_0000_0001; rready=1.
  - Required: gnt_o=01 with rom_en_o=1 and rom_addr_o=0x1000_0000 in cycle t; rvalid_o=01 with rdata_o=0xDEAD_BEEF_0000_0001 in t+1; IDLE in t+2.
- Round-robin:
  - Stimulus: req_i=11 held for 4 issues; always ready.
  - Required: grants 01,10,01,10 on consecutive cycles; rvalid follows one cycle behind each.
- Backpressure:
  - Stimulus: requester 1 granted; rready_i[1]=0 for 3 cycles, then 1; req_i[0]=1 throughout.
  - Required: rdata_o stable at the captured value for all 4 rvalid cycles; no gnt_o and rom_en_o=0 during HOLD; requester 0 granted the cycle after the handshake.
- Pipelined handoff:
  - Stimulus: requester 0 response completes in the same cycle that req_i[1]=1.
  - Required: gnt_o=10 in that same cycle; rvalid_o=10 in the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst_i low during HOLD.
  - Required: all outputs 0 immediately (asynchronous); after release, IDLE with the pointer at 0 and no stale rvalid.
- Fixed priority (SY_ROM_ARB_FIXED_PRIO_EN defined):
  - Stimulus: req_i=11 held for 3 issues.
  - Required: gnt_o=01 each time.

Source files
------------

// File: rtl/sy_rom_arb.sv
// sy_rom_arb: shares one single-port read-only ROM read port between N_REQ requesters.
// Round-robin arbitration by default; define SY_ROM_ARB_FIXED_PRIO_EN for fixed
// lowest-index-wins priority (the rotating pointer is then removed).
// One read in flight at most; a response the owner cannot take is parked in a
// hold register until its rready arrives.
module sy_rom_arb #(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] addr_i,
    output logic [N_REQ-1:0]            gnt_o,
    output logic [N_REQ-1:0]            rvalid_o,
    input  logic [N_REQ-1:0]            rready_i,
    output logic [DATA_WIDTH-1:0]       rdata_o,
    output logic                        rom_en_o,
    output logic [ADDR_WIDTH-1:0]       rom_addr_o,
    input  logic [DATA_WIDTH-1:0]       rom_rdata_i
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        HOLD
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        owner_q;
    logic [DATA_WIDTH-1:0]   data_q;
`ifndef SY_ROM_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]        ptr_q;
`endif

    logic                    owner_ready;
    logic                    can_issue;
    logic                    found;
    logic                    issue;
    logic [IDX_W-1:0]        win;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W:0]          sum;
    logic [N_REQ-1:0]        win_oh;

    assign owner_ready = rready_i[owner_q];

    // A new read may start when nothing is in flight or the current response drains this cycle; never while in reset
    always_comb begin
        can_issue = rst_i && ((state_q == IDLE) || ((state_q == RESP) && owner_ready));
    end

    // Pick the first asserted request at or after the priority start point, wrapping around
    always_comb begin
        found  = 1'b0;
        win    = '0;
        win_oh = '0;
        idx    = '0;
        sum    = '0;
        for (int i = 0; i < N_REQ; i++) begin
`ifdef SY_ROM_ARB_FIXED_PRIO_EN
            sum = (IDX_W+1)'(i);
`else
            sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
`endif
            idx = sum[IDX_W-1:0];
            if (!found && req_i[idx]) begin
                found       = 1'b1;
                win         = idx;
                win_oh[idx] = 1'b1;
            end
        end
    end

    assign issue = can_issue && found;

    // Drive the grant and ROM request in the issue cycle, and present the response to its owner
    always_comb begin
        gnt_o      = issue ? win_oh : '0;
        rom_en_o   = issue;
        rom_addr_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (issue && win_oh[k]) begin
                rom_addr_o = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        rvalid_o = '0;
        if ((state_q == RESP) || (state_q == HOLD)) begin
            rvalid_o[owner_q] = 1'b1;
        end
        rdata_o = (state_q == RESP) ? rom_rdata_i : data_q;
    end

    // Response FSM: tracks the owner of the in-flight read and parks data when the owner stalls
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            data_q  <= '0;
        end else begin
            if (issue) begin
                owner_q <= win;
            end
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    data_q <= rom_rdata_i;
                    if (owner_ready) begin
                        state_q <= issue ? RESP : IDLE;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (owner_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef SY_ROM_ARB_FIXED_PRIO_EN
    // Rotate priority to the requester just after each winner
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q <= '0;
        end else if (issue) begin
            ptr_q <= (win == IDX_W'(N_REQ-1)) ? '0 : win + IDX_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sy_rom_arb.sv
// tb_sy_rom_arb: directed self-checking bench for sy_rom_arb with N_REQ=2.
// Covers reset, single read, arbitration order, backpressure hold, pipelined
// handoff and asynchronous reset mid-hold. Honours SY_ROM_ARB_FIXED_PRIO_EN.
module tb_sy_rom_arb;

    localparam int N_REQ      = 2;
    localparam int ADDR_WIDTH = 64;
    localparam int DATA_WIDTH = 64;

    logic                        clk_i;
    logic                        rst_i;
    logic [N_REQ-1:0]            req_i;
    logic [N_REQ*ADDR_WIDTH-1:0] addr_i;
    logic [N_REQ-1:0]            gnt_o;
    logic [N_REQ-1:0]            rvalid_o;
    logic [N_REQ-1:0]            rready_i;
    logic [DATA_WIDTH-1:0]       rdata_o;
    logic                        rom_en_o;
    logic [ADDR_WIDTH-1:0]       rom_addr_o;
    logic [DATA_WIDTH-1:0]       rom_rdata_i;

    int checkCount;
    int failCount;

    sy_rom_arb #(
        .N_REQ(N_REQ),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_i(req_i),
        .addr_i(addr_i),
        .gnt_o(gnt_o),
        .rvalid_o(rvalid_o),
        .rready_i(rready_i),
        .rdata_o(rdata_o),
        .rom_en_o(rom_en_o),
        .rom_addr_o(rom_addr_o),
        .rom_rdata_i(rom_rdata_i)
    );

    // Free-running clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // ROM content is a fixed scramble of the address so every read has a distinct value
    function automatic logic [DATA_WIDTH-1:0] romModel(input logic [ADDR_WIDTH-1:0] a);
        return a ^ 64'hDEAD_BEEF_1000_0001;
    endfunction

    // ROM read port: data appears the cycle after the enable
    always @(posedge clk_i) begin
        if (rom_en_o) begin
            rom_rdata_i <= romModel(rom_addr_o);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] req, input logic [N_REQ-1:0] rdy);
        @(negedge clk_i);
        req_i    = req;
        rready_i = rdy;
        #1;
    endtask

    task automatic setAddr(input int k, input logic [ADDR_WIDTH-1:0] a);
        addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] = a;
    endtask

    // Directed sequence
    initial begin
        logic [N_REQ-1:0]      rrExp [4];
        logic [ADDR_WIDTH-1:0] rrAddr [2];
        checkCount  = 0;
        failCount   = 0;
        rst_i       = 1'b0;
        req_i       = '0;
        rready_i    = '0;
        addr_i      = '0;
        rom_rdata_i = '0;

`ifdef SY_ROM_ARB_FIXED_PRIO_EN
        rrExp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        rrExp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        rrAddr = '{64'h1000_0000, 64'h1000_0008};

        // Reset values
        @(negedge clk_i);
        #1;
        checkOutput("rst_gnt", 64'(gnt_o), 64'h0);
        checkOutput("rst_rvalid", 64'(rvalid_o), 64'h0);
        checkOutput("rst_rdata", rdata_o, 64'h0);
        checkOutput("rst_rom_en", 64'(rom_en_o), 64'h0);
        checkOutput("rst_rom_addr", rom_addr_o, 64'h0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Single read
        setAddr(0, 64'h1000_0000);
        applyStimulus(2'b01, 2'b11);
        checkOutput("single_gnt", 64'(gnt_o), 64'h1);
        checkOutput("single_rom_en", 64'(rom_en_o), 64'h1);
        checkOutput("single_rom_addr", rom_addr_o, 64'h1000_0000);
        applyStimulus(2'b00, 2'b11);
        checkOutput("single_rvalid", 64'(rvalid_o), 64'h1);
        checkOutput("single_rdata", rdata_o, 64'hDEAD_BEEF_0000_0001);
        checkOutput("single_gnt_after", 64'(gnt_o), 64'h0);
        applyStimulus(2'b00, 2'b11);
        checkOutput("single_idle_rvalid", 64'(rvalid_o), 64'h0);
        checkOutput("single_idle_rdata_held", rdata_o, 64'hDEAD_BEEF_0000_0001);

        // Restart from pointer 0 for the arbitration order check
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;

        // Round-robin with both requesting and always ready
        setAddr(0, rrAddr[0]);
        setAddr(1, rrAddr[1]);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 2'b11);
            checkOutput($sformatf("rr_gnt%0d", i), 64'(gnt_o), 64'(rrExp[i]));
            if (i > 0) begin
                checkOutput($sformatf("rr_rvalid%0d", i), 64'(rvalid_o), 64'(rrExp[i-1]));
                checkOutput($sformatf("rr_rdata%0d", i), rdata_o,
                            romModel(rrAddr[rrExp[i-1] == 2'b10 ? 1 : 0]));
            end
        end
        applyStimulus(2'b00, 2'b11);
        checkOutput("rr_last_rvalid", 64'(rvalid_o), 64'(rrExp[3]));
        checkOutput("rr_last_rdata", rdata_o, romModel(rrAddr[rrExp[3] == 2'b10 ? 1 : 0]));
        checkOutput("rr_last_gnt", 64'(gnt_o), 64'h0);

        // Backpressure on requester 1 while requester 0 keeps asking
        setAddr(1, 64'h2000_0040);
        setAddr(0, 64'h1000_0010);
        applyStimulus(2'b10, 2'b01);
        checkOutput("bp_gnt1", 64'(gnt_o), 64'h2);
        checkOutput("bp_rom_addr", rom_addr_o, 64'h2000_0040);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(2'b01, (c == 3) ? 2'b11 : 2'b01);
            checkOutput($sformatf("bp_rvalid%0d", c), 64'(rvalid_o), 64'h2);
            checkOutput($sformatf("bp_rdata%0d", c), rdata_o, romModel(64'h2000_0040));
            checkOutput($sformatf("bp_gnt%0d", c), 64'(gnt_o), 64'h0);
            checkOutput($sformatf("bp_rom_en%0d", c), 64'(rom_en_o), 64'h0);
        end
        applyStimulus(2'b01, 2'b11);
        checkOutput("bp_after_gnt", 64'(gnt_o), 64'h1);
        checkOutput("bp_after_rom_en", 64'(rom_en_o), 64'h1);
        checkOutput("bp_after_rom_addr", rom_addr_o, 64'h1000_0010);
        checkOutput("bp_after_rvalid", 64'(rvalid_o), 64'h0);

        // Pipelined handoff: requester 1 granted as requester 0 completes
        setAddr(1, 64'h3000_0100);
        applyStimulus(2'b10, 2'b11);
        checkOutput("ho_rvalid0", 64'(rvalid_o), 64'h1);
        checkOutput("ho_rdata0", rdata_o, romModel(64'h1000_0010));
        checkOutput("ho_gnt", 64'(gnt_o), 64'h2);
        checkOutput("ho_rom_addr", rom_addr_o, 64'h3000_0100);
        applyStimulus(2'b00, 2'b11);
        checkOutput("ho_rvalid1", 64'(rvalid_o), 64'h2);
        checkOutput("ho_rdata1", rdata_o, romModel(64'h3000_0100));
        checkOutput("ho_gnt_after", 64'(gnt_o), 64'h0);

        // Reset in the middle of a held response
        applyStimulus(2'b01, 2'b00);
        checkOutput("mr_gnt", 64'(gnt_o), 64'h1);
        applyStimulus(2'b01, 2'b00);
        checkOutput("mr_resp_rvalid", 64'(rvalid_o), 64'h1);
        checkOutput("mr_resp_gnt", 64'(gnt_o), 64'h0);
        applyStimulus(2'b01, 2'b00);
        checkOutput("mr_hold_rvalid", 64'(rvalid_o), 64'h1);
        checkOutput("mr_hold_rdata", rdata_o, romModel(64'h1000_0010));
        #2;
        rst_i = 1'b0;
        #1;
        checkOutput("mr_async_gnt", 64'(gnt_o), 64'h0);
        checkOutput("mr_async_rvalid", 64'(rvalid_o), 64'h0);
        checkOutput("mr_async_rdata", rdata_o, 64'h0);
        checkOutput("mr_async_rom_en", 64'(rom_en_o), 64'h0);
        checkOutput("mr_async_rom_addr", rom_addr_o, 64'h0);
        @(negedge clk_i);
        req_i    = 2'b00;
        rready_i = 2'b11;
        rst_i    = 1'b1;
        #1;
        checkOutput("mr_post_rvalid0", 64'(rvalid_o), 64'h0);
        applyStimulus(2'b00, 2'b11);
        checkOutput("mr_post_rvalid1", 64'(rvalid_o), 64'h0);
        checkOutput("mr_post_rdata", rdata_o, 64'h0);
        applyStimulus(2'b11, 2'b11);
        checkOutput("mr_ptr0_gnt", 64'(gnt_o), 64'h1);
        applyStimulus(2'b00, 2'b11);
        checkOutput("mr_ptr0_rvalid", 64'(rvalid_o), 64'h1);
        checkOutput("mr_ptr0_rdata", rdata_o, romModel(64'h1000_0010));

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
